// File: rtl/traffic_pkg.sv
// Shared constants for the round-robin traffic controller.
// Latency: none (types, constants and a width helper only).
// Backpressure: not applicable.
//
// Contents: light codes LT_*, phase encoding phase_e (PH_*), and the dir_w()
// helper that sizes the approach index.
package traffic_pkg;

  localparam logic [1:0] LT_GREEN  = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_RED    = 2'b10;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10
  } phase_e;

  // Width of an approach index; never below 1 so a 2-way build still has a bit.
  function automatic int dir_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/traffic_ctrl_rr_rr_next_dir.sv
// Cyclic priority picker: first requesting approach after the current one.
// Latency: purely combinational.
// Backpressure: none; it is evaluated every cycle and the caller samples it.
//
// Ports: i_req      request mask, one bit per approach
//        i_cur_dir  approach that currently holds the right of way
//        o_next_dir nearest requester after i_cur_dir (cyclic), or
//                   i_cur_dir+1 (mod NUM_DIR) when nobody else is requesting
module rr_next_dir
  import traffic_pkg::*;
#(
  parameter  int NUM_DIR = 2,
  localparam int DIR_W   = dir_w(NUM_DIR)
) (
  input  logic [NUM_DIR-1:0] i_req,
  input  logic [DIR_W-1:0]   i_cur_dir,
  output logic [DIR_W-1:0]   o_next_dir
);

  always_comb begin
    int w_cur;
    int w_best;
    int w_best_d;
    int w_dist;
    w_cur    = int'(i_cur_dir);
    w_best   = (w_cur + 1 >= NUM_DIR) ? 0 : w_cur + 1;
    w_best_d = NUM_DIR;
    w_dist   = 0;
    for (int j = 0; j < NUM_DIR; j++) begin
      // Cyclic distance from the current holder; the holder itself is NUM_DIR
      // away and therefore never chosen.
      w_dist = (j > w_cur) ? (j - w_cur) : (j + NUM_DIR - w_cur);
      if (i_req[j] && (w_dist < w_best_d)) begin
        w_best   = j;
        w_best_d = w_dist;
      end
    end
    o_next_dir = DIR_W'(w_best);
  end

endmodule

// File: rtl/traffic_ctrl_rr.sv
// Round-robin Moore traffic-light controller for NUM_DIR approaches.
// Latency: sensor to state 1 cycle; lights are decoded from registers only.
// Backpressure: none; sensor requests are held in a sticky pending mask.
//
// Ports: clk, reset (sync, active high), T[NUM_DIR] vehicle sensors,
//        L[2*NUM_DIR] light codes (approach i on L[2i+1:2i]),
//        cur_dir approach holding the right of way, phase (00 G/01 Y/10 AR).
// Build option: define TRAFFIC_ALL_RED_EN to insert the all-red phase.
module traffic_ctrl_rr
  import traffic_pkg::*;
#(
  parameter  int NUM_DIR     = 2,
  parameter  int GREEN_MIN   = 4,
  parameter  int GREEN_MAX   = 12,
  parameter  int YELLOW_CYC  = 2,
  parameter  int ALL_RED_CYC = 1,
  localparam int DIR_W       = dir_w(NUM_DIR)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_DIR-1:0]   T,
  output logic [2*NUM_DIR-1:0] L,
  output logic [DIR_W-1:0]     cur_dir,
  output logic [1:0]           phase
);

  // One counter serves every phase, so it is sized for the longest one.
  localparam int CNT_MAX_GY = (GREEN_MAX > YELLOW_CYC) ? GREEN_MAX : YELLOW_CYC;
  localparam int CNT_MAX    = (CNT_MAX_GY > ALL_RED_CYC) ? CNT_MAX_GY : ALL_RED_CYC;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  phase_e             r_phase, w_phase_nxt;
  logic [DIR_W-1:0]   r_dir,   w_dir_nxt;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic [NUM_DIR-1:0] r_pend,  w_pend_nxt;

  logic [NUM_DIR-1:0] w_req;
  logic [NUM_DIR-1:0] w_cur_mask;
  logic               w_other_req;
  logic               w_at_max;
  logic               w_min_met;
  logic               w_grant;
  logic [DIR_W-1:0]   w_rr_dir;

  assign w_req       = r_pend | T;
  assign w_cur_mask  = NUM_DIR'(1) << r_dir;
  assign w_other_req = |(w_req & ~w_cur_mask);
  assign w_at_max    = (r_cnt == CNT_W'(GREEN_MAX - 1));
  assign w_min_met   = (r_cnt >= CNT_W'(GREEN_MIN - 1));

  rr_next_dir #(
    .NUM_DIR(NUM_DIR)
  ) u_rr_next_dir (
    .i_req      (w_req),
    .i_cur_dir  (r_dir),
    .o_next_dir (w_rr_dir)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= PH_GREEN;
      r_dir   <= '0;
      r_cnt   <= '0;
      r_pend  <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      r_dir   <= w_dir_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_dir_nxt   = r_dir;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    unique case (r_phase)
      PH_GREEN: begin
        // Leave only when someone else waits and either the max is reached or
        // the minimum is served and the current approach has emptied.
        if (w_other_req && (w_at_max || (w_min_met && !T[r_dir]))) begin
          w_phase_nxt = PH_YELLOW;
          w_cnt_nxt   = '0;
        end else if (!w_at_max) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      PH_YELLOW: begin
        if (r_cnt == CNT_W'(YELLOW_CYC - 1)) begin
          w_cnt_nxt = '0;
`ifdef TRAFFIC_ALL_RED_EN
          w_phase_nxt = PH_ALLRED;
`else
          w_phase_nxt = PH_GREEN;
          w_dir_nxt   = w_rr_dir;
          w_grant     = 1'b1;
`endif
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      PH_ALLRED: begin
        if (r_cnt == CNT_W'(ALL_RED_CYC - 1)) begin
          w_phase_nxt = PH_GREEN;
          w_dir_nxt   = w_rr_dir;
          w_cnt_nxt   = '0;
          w_grant     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_phase_nxt = PH_GREEN;
        w_cnt_nxt   = '0;
      end
    endcase
    // The granted approach is cleared even if its sensor is high this cycle.
    w_pend_nxt = w_req & ~(w_grant ? (NUM_DIR'(1) << w_rr_dir) : NUM_DIR'(0));
  end

  always_comb begin
    L = {NUM_DIR{LT_RED}};
    for (int i = 0; i < NUM_DIR; i++) begin
      if (r_dir == DIR_W'(i)) begin
        L[2*i +: 2] = (r_phase == PH_GREEN)  ? LT_GREEN  :
                      (r_phase == PH_YELLOW) ? LT_YELLOW : LT_RED;
      end
    end
  end

  assign cur_dir = r_dir;
  assign phase   = r_phase;

endmodule

// File: tb/tb_traffic_ctrl_rr.sv
// Directed bench for traffic_ctrl_rr (2-way and 3-way instances).
// Latency: observes registered outputs 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_traffic_ctrl_rr;

`ifdef TRAFFIC_ALL_RED_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] t2;
  logic [3:0] l2;
  logic [0:0] dir2;
  logic [1:0] ph2;
  logic [2:0] t3;
  logic [5:0] l3;
  logic [1:0] dir3;
  logic [1:0] ph3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  traffic_ctrl_rr dut (
    .clk     (clk),
    .reset   (reset),
    .T       (t2),
    .L       (l2),
    .cur_dir (dir2),
    .phase   (ph2)
  );

  traffic_ctrl_rr #(.NUM_DIR(3)) dut3 (
    .clk     (clk),
    .reset   (reset),
    .T       (t3),
    .L       (l3),
    .cur_dir (dir3),
    .phase   (ph3)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    t2    = 2'b00;
    t3    = 3'b000;
    step();
    step();
    reset = 1'b0;
  endtask

  // Expected 2-way lights/phase c cycles after a request on approach 1 only.
  function automatic logic [3:0] exp_l(input int c);
    if (c < 4)           return 4'b1000;
    else if (c < 6)      return 4'b1001;
    else if (c < 6 + AR) return 4'b1010;
    else                 return 4'b0010;
  endfunction

  function automatic logic [1:0] exp_ph(input int c);
    if (c < 4)           return 2'b00;
    else if (c < 6)      return 2'b01;
    else if (c < 6 + AR) return 2'b10;
    else                 return 2'b00;
  endfunction

  task automatic run_seq(input bit pulse, input string nm);
    do_reset();
    t2 = 2'b10;
    for (int c = 0; c < 10; c++) begin
      if (pulse && c == 1) t2 = 2'b00;
      check_val($sformatf("%s_L_c%0d", nm, c), 32'(l2), 32'(exp_l(c)));
      check_val($sformatf("%s_ph_c%0d", nm, c), 32'(ph2), 32'(exp_ph(c)));
      step();
    end
    check_val($sformatf("%s_dir", nm), 32'(dir2), 32'd1);
    if (pulse) check_val("pulse_pend1", 32'(dut.r_pend[1]), 32'd0);
  endtask

  initial begin
    int n;
    int len;
    int gap;

    // Idle: no demand, approach 0 stays green.
    do_reset();
    check_val("rst_L", 32'(l2), 32'h8);
    check_val("rst_cnt", 32'(dut.r_cnt), 32'd0);
    check_val("rst_pend", 32'(dut.r_pend), 32'd0);
    for (int c = 0; c < 50; c++) begin
      check_val($sformatf("idle_L_c%0d", c), 32'(l2), 32'h8);
      check_val($sformatf("idle_ph_c%0d", c), 32'(ph2), 32'd0);
      step();
    end

    run_seq(1'b0, "held");
    run_seq(1'b1, "pulse");

    // Both approaches always busy: every green runs to the maximum.
    do_reset();
    t2 = 2'b11;
    for (int g = 0; g < 3; g++) begin
      check_val($sformatf("busy_dir_g%0d", g), 32'(dir2), 32'(g % 2));
      len = 0;
      while (ph2 == 2'b00 && len < 40) begin
        step();
        len++;
      end
      check_val($sformatf("busy_glen_g%0d", g), 32'(len), 32'd12);
      if (g < 2) begin
        gap = 0;
        while (ph2 != 2'b00 && gap < 20) begin
          step();
          gap++;
        end
        check_val($sformatf("busy_gap_g%0d", g), 32'(gap), 32'(2 + AR));
      end
    end

    // 3-way: pulse on 2 skips 1; later pulse on 0 wraps from 2.
    do_reset();
    t3 = 3'b100;
    step();
    t3 = 3'b000;
    n = 0;
    while (dir3 == 2'd0 && n < 50) begin
      step();
      n++;
    end
    check_val("d3_skip_dir", 32'(dir3), 32'd2);
    check_val("d3_skip_ph", 32'(ph3), 32'd0);
    check_val("d3_skip_L", 32'(l3), 32'h0A);
    t3 = 3'b001;
    step();
    t3 = 3'b000;
    n = 0;
    while (dir3 == 2'd2 && n < 50) begin
      step();
      n++;
    end
    check_val("d3_wrap_dir", 32'(dir3), 32'd0);
    check_val("d3_wrap_L", 32'(l3), 32'h28);

    // Reset on the second yellow cycle with demand still present.
    do_reset();
    t2 = 2'b10;
    n = 0;
    while (ph2 != 2'b01 && n < 50) begin
      step();
      n++;
    end
    check_val("mid_reach_yel", 32'(ph2), 32'd1);
    step();
    check_val("mid_yel2", 32'(ph2), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("mid_L", 32'(l2), 32'h8);
    check_val("mid_ph", 32'(ph2), 32'd0);
    check_val("mid_dir", 32'(dir2), 32'd0);
    check_val("mid_cnt", 32'(dut.r_cnt), 32'd0);
    check_val("mid_pend", 32'(dut.r_pend), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
